// File: rtl/mem_pkg.sv
// Shared constants and queue-entry layout for the MEM stage and its helpers.
package mem_pkg;

    localparam logic [1:0] LD_B = 2'b00;
    localparam logic [1:0] LD_H = 2'b01;
    localparam logic [1:0] LD_W = 2'b10;

    // Entries reserve the widest sideband; narrower configurations use the low bits.
    localparam int SIDE_W_MAX = 64;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           alu_result;
        logic [4:0]            dest;
        logic                  gr_we;
        logic                  is_load;
        logic                  is_mem;
        logic [1:0]            size;
        logic                  uns;
        logic                  ex;
        logic                  resp;
        logic [31:0]           data;
        logic [SIDE_W_MAX-1:0] side;
    } mem_entry_t;

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half/word out of a 32-bit load beat and extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Halfwords are selected by bit 1 only; bit 0 is ignored for them.
    always_comb begin
        byte_val = rdata[{offset, 3'b000} +: 8];
        half_val = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            LD_B:    result = {{24{~uns & byte_val[7]}}, byte_val};
            LD_H:    result = {{16{~uns & half_val[15]}}, half_val};
            LD_W:    result = rdata;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_mq.sv
// MEM stage with an in-order queue of outstanding data-SRAM requests; responses
// complete the oldest waiting entry and entries retire in order to WB.
module mem_stage_mq
    import mem_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int SIDE_W = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              exe_to_mem_valid,
    output logic              mem_allowin,
    input  logic [31:0]       exe_pc,
    input  logic [31:0]       exe_alu_result,
    input  logic [4:0]        exe_dest,
    input  logic              exe_gr_we,
    input  logic              exe_load_op,
    input  logic              exe_mem_we,
    input  logic [1:0]        exe_ld_size,
    input  logic              exe_ld_unsigned,
    input  logic              exe_ex,
    input  logic [SIDE_W-1:0] exe_side,

    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,

    input  logic              flush,

    input  logic              wb_allowin,
    output logic              mem_to_wb_valid,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_result,
    output logic [4:0]        wb_dest,
    output logic              wb_gr_we,
    output logic              wb_ex,
    output logic [SIDE_W-1:0] wb_side,

    output logic              mem_has_ex,

    input  logic [4:0]        fwd_raddr1,
    input  logic [4:0]        fwd_raddr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic              fwd_rdy1,
    output logic              fwd_rdy2,
    output logic [31:0]       fwd_data1,
    output logic [31:0]       fwd_data2
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int DISC_W = PTR_W + 4;

    mem_entry_t        q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [DISC_W-1:0] discard_cnt;

    logic [PTR_W-1:0]  resp_ptr;
    logic [PTR_W-1:0]  scan_idx;
    logic [PTR_W-1:0]  fwd_idx;
    logic [CNT_W-1:0]  waiting_cnt;
    logic              resp_found;
    logic              resp_fire;
    logic              head_arrive;
    logic              head_ready;
    logic              full;
    logic              offer_is_mem;
    logic              push;
    logic              pop;
    logic [31:0]       aligned;
    logic [31:0]       head_data;
    mem_entry_t        head_e;
    mem_entry_t        resp_e;
    mem_entry_t        new_entry;

    assign full         = (count == CNT_W'(DEPTH));
    assign mem_allowin  = ~full;
    assign offer_is_mem = (exe_load_op | exe_mem_we) & ~exe_ex;
    assign push         = exe_to_mem_valid & mem_allowin & ~flush;

    // Walk valid entries oldest-first: find the response target and count waiters.
    always_comb begin
        resp_found  = 1'b0;
        resp_ptr    = head;
        scan_idx    = head;
        waiting_cnt = '0;
        mem_has_ex  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (q[scan_idx].is_mem && !q[scan_idx].resp) begin
                    waiting_cnt = waiting_cnt + CNT_W'(1);
                    if (!resp_found) begin
                        resp_found = 1'b1;
                        resp_ptr   = scan_idx;
                    end
                end
                if (q[scan_idx].ex) begin
                    mem_has_ex = 1'b1;
                end
            end
        end
    end

    assign resp_e    = q[resp_ptr];
    assign head_e    = q[head];
    assign resp_fire = data_sram_data_ok & (discard_cnt == '0) & resp_found;

    mem_load_align u_align (
        .rdata  (data_sram_rdata),
        .offset (resp_e.alu_result[1:0]),
        .size   (resp_e.size),
        .uns    (resp_e.uns),
        .result (aligned)
    );

    // A beat landing on the head retires it in the same cycle.
    assign head_arrive     = resp_fire & (resp_ptr == head);
    assign head_data       = head_arrive ? aligned : head_e.data;
    assign head_ready      = (count != '0) & (~head_e.is_mem | head_e.resp | head_arrive);
    assign mem_to_wb_valid = head_ready & ~flush;
    assign pop             = mem_to_wb_valid & wb_allowin;

    assign wb_pc     = head_e.pc;
    assign wb_result = head_e.is_load ? head_data : head_e.alu_result;
    assign wb_dest   = head_e.dest;
    assign wb_gr_we  = head_e.gr_we;
    assign wb_ex     = head_e.ex;
    assign wb_side   = head_e.side[SIDE_W-1:0];

    always_comb begin
        new_entry            = '0;
        new_entry.pc         = exe_pc;
        new_entry.alu_result = exe_alu_result;
        new_entry.dest       = exe_dest;
        new_entry.gr_we      = exe_gr_we;
        new_entry.is_load    = exe_load_op & ~exe_ex;
        new_entry.is_mem     = offer_is_mem;
        new_entry.size       = exe_ld_size;
        new_entry.uns        = exe_ld_unsigned;
        new_entry.ex         = exe_ex;
        new_entry.side       = SIDE_W_MAX'(exe_side);
    end

    // Later (younger) matches override earlier ones.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_rdy1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_rdy2  = 1'b0;
        fwd_data2 = '0;
        fwd_idx   = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PTR_W'(i);
            if (CNT_W'(i) < count && q[fwd_idx].gr_we && q[fwd_idx].dest != 5'd0) begin
                if (q[fwd_idx].dest == fwd_raddr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_rdy1  = ~q[fwd_idx].is_load | q[fwd_idx].resp;
                    fwd_data1 = q[fwd_idx].is_load ? q[fwd_idx].data : q[fwd_idx].alu_result;
                end
                if (q[fwd_idx].dest == fwd_raddr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_rdy2  = ~q[fwd_idx].is_load | q[fwd_idx].resp;
                    fwd_data2 = q[fwd_idx].is_load ? q[fwd_idx].data : q[fwd_idx].alu_result;
                end
            end
        end
    end

    // On flush, requests still in flight become beats to swallow later.
    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            discard_cnt <= '0;
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            discard_cnt <= discard_cnt + DISC_W'(waiting_cnt)
                         + DISC_W'(exe_to_mem_valid & mem_allowin & offer_is_mem)
                         - DISC_W'(data_sram_data_ok);
        end else begin
            if (data_sram_data_ok && discard_cnt != '0) begin
                discard_cnt <= discard_cnt - DISC_W'(1);
            end
            if (resp_fire) begin
                q[resp_ptr].resp <= 1'b1;
                q[resp_ptr].data <= aligned;
            end
            if (push) begin
                q[tail] <= new_entry;
                tail    <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always @(posedge clk) begin
        if (!reset && data_sram_data_ok && discard_cnt == '0) begin
            assert (resp_found);
        end
    end

endmodule

// File: tb/tb_mem_stage_mq.sv
// Bench for mem_stage_mq: directed scenarios followed by random traffic against a queue model.
module tb_mem_stage_mq;

    localparam int DEPTH  = 2;
    localparam int SIDE_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              exe_to_mem_valid;
    logic              mem_allowin;
    logic [31:0]       exe_pc;
    logic [31:0]       exe_alu_result;
    logic [4:0]        exe_dest;
    logic              exe_gr_we;
    logic              exe_load_op;
    logic              exe_mem_we;
    logic [1:0]        exe_ld_size;
    logic              exe_ld_unsigned;
    logic              exe_ex;
    logic [SIDE_W-1:0] exe_side;
    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;
    logic              flush;
    logic              wb_allowin;
    logic              mem_to_wb_valid;
    logic [31:0]       wb_pc;
    logic [31:0]       wb_result;
    logic [4:0]        wb_dest;
    logic              wb_gr_we;
    logic              wb_ex;
    logic [SIDE_W-1:0] wb_side;
    logic              mem_has_ex;
    logic [4:0]        fwd_raddr1;
    logic [4:0]        fwd_raddr2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic              fwd_rdy1;
    logic              fwd_rdy2;
    logic [31:0]       fwd_data1;
    logic [31:0]       fwd_data2;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_mq #(.DEPTH(DEPTH), .SIDE_W(SIDE_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .exe_to_mem_valid  (exe_to_mem_valid),
        .mem_allowin       (mem_allowin),
        .exe_pc            (exe_pc),
        .exe_alu_result    (exe_alu_result),
        .exe_dest          (exe_dest),
        .exe_gr_we         (exe_gr_we),
        .exe_load_op       (exe_load_op),
        .exe_mem_we        (exe_mem_we),
        .exe_ld_size       (exe_ld_size),
        .exe_ld_unsigned   (exe_ld_unsigned),
        .exe_ex            (exe_ex),
        .exe_side          (exe_side),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .wb_pc             (wb_pc),
        .wb_result         (wb_result),
        .wb_dest           (wb_dest),
        .wb_gr_we          (wb_gr_we),
        .wb_ex             (wb_ex),
        .wb_side           (wb_side),
        .mem_has_ex        (mem_has_ex),
        .fwd_raddr1        (fwd_raddr1),
        .fwd_raddr2        (fwd_raddr2),
        .fwd_hit1          (fwd_hit1),
        .fwd_hit2          (fwd_hit2),
        .fwd_rdy1          (fwd_rdy1),
        .fwd_rdy2          (fwd_rdy2),
        .fwd_data1         (fwd_data1),
        .fwd_data2         (fwd_data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        gr_we;
        logic        load;
        logic        mem;
        logic [1:0]  size;
        logic        uns;
        logic        ex;
        logic        got;
        logic [31:0] data;
        logic [63:0] side;
    } model_entry_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exe_to_mem_valid  = 1'b0;
        exe_pc            = '0;
        exe_alu_result    = '0;
        exe_dest          = '0;
        exe_gr_we         = 1'b0;
        exe_load_op       = 1'b0;
        exe_mem_we        = 1'b0;
        exe_ld_size       = 2'b10;
        exe_ld_unsigned   = 1'b0;
        exe_ex            = 1'b0;
        exe_side          = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        flush             = 1'b0;
        wb_allowin        = 1'b1;
        fwd_raddr1        = '0;
        fwd_raddr2        = '0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] dest,
                         input logic gr_we, input logic ld, input logic st,
                         input logic [1:0] size, input logic uns, input logic ex);
        exe_to_mem_valid = 1'b1;
        exe_pc           = pc;
        exe_alu_result   = alu;
        exe_dest         = dest;
        exe_gr_we        = gr_we;
        exe_load_op      = ld;
        exe_mem_we       = st;
        exe_ld_size      = size;
        exe_ld_unsigned  = uns;
        exe_ex           = ex;
    endtask

    function automatic logic [31:0] ref_align(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [1:0] size, input logic uns);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (rdata >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (rdata >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic test_reset();
        idle();
        reset = 1'b1;
        fwd_raddr1 = 5'd5;
        tick();
        tick();
        n_cmp++; if (mem_to_wb_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b want 0", mem_to_wb_valid); end
        n_cmp++; if (mem_allowin !== 1'b1) begin n_err++; $display("[TB] FAIL reset_allowin: got %b want 1", mem_allowin); end
        n_cmp++; if (fwd_hit1 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_hit1: got %b want 0", fwd_hit1); end
        n_cmp++; if (mem_has_ex !== 1'b0) begin n_err++; $display("[TB] FAIL reset_has_ex: got %b want 0", mem_has_ex); end
        reset = 1'b0;
        idle();
    endtask

    task automatic test_load_bypass();
        offer(32'h1000, 32'h100, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (mem_to_wb_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bypass_valid: got %b want 1", mem_to_wb_valid); end
        n_cmp++; if (wb_result !== 32'hDEAD_BEEF) begin n_err++; $display("[TB] FAIL bypass_result: got %h want deadbeef", wb_result); end
        n_cmp++; if (wb_pc !== 32'h1000) begin n_err++; $display("[TB] FAIL bypass_pc: got %h want 00001000", wb_pc); end
        tick();
        idle();
        #1;
        n_cmp++; if (mem_to_wb_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bypass_drained: got %b want 0", mem_to_wb_valid); end
    endtask

    task automatic test_align();
        logic [31:0] addr [3] = '{32'h103, 32'h103, 32'h102};
        logic [1:0]  sz   [3] = '{2'b00, 2'b00, 2'b01};
        logic        un   [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] want [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012};
        for (int k = 0; k < 3; k++) begin
            offer(32'h2000 + 32'(k * 4), addr[k], 5'd7, 1'b1, 1'b1, 1'b0, sz[k], un[k], 1'b0);
            tick();
            idle();
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'h8012_3456;
            #1;
            n_cmp++; if (wb_result !== want[k]) begin n_err++; $display("[TB] FAIL align_%0d: got %h want %h", k, wb_result, want[k]); end
            tick();
            idle();
        end
    endtask

    task automatic test_in_order();
        offer(32'h200, 32'h40, 5'd1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        offer(32'h204, 32'h44, 5'd2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        idle();
        wb_allowin = 1'b0;
        #1;
        n_cmp++; if (mem_allowin !== 1'b0) begin n_err++; $display("[TB] FAIL full_allowin: got %b want 0", mem_allowin); end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11;
        tick();
        data_sram_rdata   = 32'h22;
        tick();
        idle();
        wb_allowin = 1'b0;
        #1;
        n_cmp++; if (mem_to_wb_valid !== 1'b1 || wb_result !== 32'h11) begin n_err++; $display("[TB] FAIL order_first: got v=%b %h want v=1 00000011", mem_to_wb_valid, wb_result); end
        wb_allowin = 1'b1;
        tick();
        n_cmp++; if (mem_to_wb_valid !== 1'b1 || wb_result !== 32'h22 || wb_pc !== 32'h204) begin n_err++; $display("[TB] FAIL order_second: got v=%b %h pc=%h want v=1 00000022 pc=00000204", mem_to_wb_valid, wb_result, wb_pc); end
        tick();
        n_cmp++; if (mem_to_wb_valid !== 1'b0) begin n_err++; $display("[TB] FAIL order_empty: got %b want 0", mem_to_wb_valid); end
    endtask

    task automatic test_flush_discard();
        offer(32'h300, 32'h80, 5'd3, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        offer(32'h304, 32'h84, 5'd3, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        idle();
        flush = 1'b1;
        tick();
        idle();
        #1;
        n_cmp++; if (mem_allowin !== 1'b1 || mem_to_wb_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_empty: got allowin=%b v=%b want 1 0", mem_allowin, mem_to_wb_valid); end
        offer(32'h308, 32'h88, 5'd3, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        idle();
        for (int b = 0; b < 2; b++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'hAAAA_0000 + 32'(b);
            #1;
            n_cmp++; if (mem_to_wb_valid !== 1'b0) begin n_err++; $display("[TB] FAIL discard_beat_%0d: got v=%b want 0", b, mem_to_wb_valid); end
            tick();
        end
        data_sram_rdata = 32'h3333_3333;
        #1;
        n_cmp++; if (mem_to_wb_valid !== 1'b1 || wb_result !== 32'h3333_3333) begin n_err++; $display("[TB] FAIL discard_third: got v=%b %h want v=1 33333333", mem_to_wb_valid, wb_result); end
        tick();
        idle();
    endtask

    task automatic test_flush_same_cycle();
        offer(32'h400, 32'h90, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        offer(32'h404, 32'h94, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        flush             = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h55;
        #1;
        n_cmp++; if (mem_to_wb_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_blocks_wb: got %b want 0", mem_to_wb_valid); end
        tick();
        idle();
        offer(32'h408, 32'h98, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h66;
        #1;
        n_cmp++; if (mem_to_wb_valid !== 1'b0) begin n_err++; $display("[TB] FAIL samecyc_discard: got %b want 0", mem_to_wb_valid); end
        tick();
        data_sram_rdata = 32'h77;
        #1;
        n_cmp++; if (mem_to_wb_valid !== 1'b1 || wb_result !== 32'h77 || wb_pc !== 32'h408) begin n_err++; $display("[TB] FAIL samecyc_own: got v=%b %h pc=%h want v=1 00000077 pc=00000408", mem_to_wb_valid, wb_result, wb_pc); end
        tick();
        idle();
    endtask

    task automatic test_forward();
        offer(32'h500, 32'hA0, 5'd5, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        idle();
        wb_allowin = 1'b0;
        fwd_raddr1 = 5'd5;
        #1;
        n_cmp++; if (fwd_hit1 !== 1'b1 || fwd_rdy1 !== 1'b0) begin n_err++; $display("[TB] FAIL fwd_load_wait: got hit=%b rdy=%b want 1 0", fwd_hit1, fwd_rdy1); end
        n_cmp++; if (fwd_hit2 !== 1'b0) begin n_err++; $display("[TB] FAIL fwd_r0: got hit2=%b want 0", fwd_hit2); end
        offer(32'h504, 32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        tick();
        idle();
        wb_allowin = 1'b0;
        fwd_raddr1 = 5'd5;
        fwd_raddr2 = 5'd5;
        #1;
        n_cmp++; if (fwd_hit1 !== 1'b1 || fwd_rdy1 !== 1'b1 || fwd_data1 !== 32'h1234) begin n_err++; $display("[TB] FAIL fwd_youngest1: got %b %b %h want 1 1 00001234", fwd_hit1, fwd_rdy1, fwd_data1); end
        n_cmp++; if (fwd_hit2 !== 1'b1 || fwd_rdy2 !== 1'b1 || fwd_data2 !== 32'h1234) begin n_err++; $display("[TB] FAIL fwd_youngest2: got %b %b %h want 1 1 00001234", fwd_hit2, fwd_rdy2, fwd_data2); end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        wb_allowin        = 1'b1;
        tick();
        idle();
        tick();
    endtask

    task automatic test_exception();
        offer(32'h600, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
        exe_side = 64'hA5A5_0000_1234_5678;
        tick();
        idle();
        wb_allowin = 1'b0;
        #1;
        n_cmp++; if (mem_has_ex !== 1'b1) begin n_err++; $display("[TB] FAIL ex_flag: got %b want 1", mem_has_ex); end
        n_cmp++; if (mem_to_wb_valid !== 1'b1 || wb_ex !== 1'b1 || wb_side !== 64'hA5A5_0000_1234_5678) begin n_err++; $display("[TB] FAIL ex_retire: got v=%b ex=%b side=%h", mem_to_wb_valid, wb_ex, wb_side); end
        wb_allowin = 1'b1;
        tick();
        n_cmp++; if (mem_has_ex !== 1'b0) begin n_err++; $display("[TB] FAIL ex_cleared: got %b want 0", mem_has_ex); end
    endtask

    task automatic test_random();
        model_entry_t mq[$];
        model_entry_t ne;
        int discard;
        int waiting;
        int tgt;
        int kind;
        logic [31:0] arrive;
        logic [31:0] exp_res;
        logic exp_allowin, exp_valid, exp_ex, accept;
        logic [4:0] ra [2];
        logic [2:0] got_fwd [2];
        logic [31:0] got_fdata [2];
        logic e_hit, e_rdy;
        logic [31:0] e_data;

        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        discard = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            waiting = 0;
            foreach (mq[j]) if (mq[j].mem && !mq[j].got) waiting++;
            kind = int'($urandom_range(0, 9));
            ne.pc    = $urandom;
            ne.alu   = $urandom;
            ne.dest  = 5'($urandom_range(0, 3));
            ne.gr_we = 1'($urandom_range(0, 1));
            ne.ex    = (kind == 9);
            ne.load  = (kind < 4);
            ne.mem   = (kind < 7);
            ne.size  = 2'($urandom_range(0, 2));
            ne.uns   = 1'($urandom_range(0, 1));
            ne.side  = {$urandom, $urandom};
            ne.got   = 1'b0;
            ne.data  = '0;
            if ($urandom_range(0, 99) < 60) begin
                offer(ne.pc, ne.alu, ne.dest, ne.gr_we, ne.load, ne.mem & ~ne.load, ne.size, ne.uns, ne.ex);
                exe_side = ne.side;
            end
            data_sram_data_ok = (discard + waiting > 0) && ($urandom_range(0, 99) < 50);
            data_sram_rdata   = $urandom;
            flush             = ($urandom_range(0, 99) < 4);
            wb_allowin        = ($urandom_range(0, 99) < 70);
            fwd_raddr1        = 5'($urandom_range(0, 3));
            fwd_raddr2        = 5'($urandom_range(0, 3));
            #1;

            tgt = -1;
            arrive = '0;
            if (data_sram_data_ok && discard == 0) begin
                for (int j = 0; j < mq.size(); j++) if (tgt < 0 && mq[j].mem && !mq[j].got) tgt = j;
                if (tgt >= 0) arrive = ref_align(data_sram_rdata, mq[tgt].alu, mq[tgt].size, mq[tgt].uns);
            end
            exp_allowin = (mq.size() < DEPTH);
            exp_valid = (mq.size() > 0) && (!mq[0].mem || mq[0].got || tgt == 0) && !flush;
            exp_ex = 1'b0;
            foreach (mq[j]) if (mq[j].ex) exp_ex = 1'b1;

            n_cmp++; if (mem_allowin !== exp_allowin) begin n_err++; $display("[TB] FAIL rnd_allowin cyc %0d: got %b want %b", cyc, mem_allowin, exp_allowin); end
            n_cmp++; if (mem_to_wb_valid !== exp_valid) begin n_err++; $display("[TB] FAIL rnd_valid cyc %0d: got %b want %b", cyc, mem_to_wb_valid, exp_valid); end
            n_cmp++; if (mem_has_ex !== exp_ex) begin n_err++; $display("[TB] FAIL rnd_has_ex cyc %0d: got %b want %b", cyc, mem_has_ex, exp_ex); end
            if (exp_valid) begin
                if (mq[0].load && mq[0].mem) exp_res = mq[0].got ? mq[0].data : arrive;
                else exp_res = mq[0].alu;
                n_cmp++;
                if (wb_pc !== mq[0].pc || wb_result !== exp_res || wb_dest !== mq[0].dest ||
                    wb_gr_we !== mq[0].gr_we || wb_ex !== mq[0].ex || wb_side !== mq[0].side) begin
                    n_err++;
                    $display("[TB] FAIL rnd_wb cyc %0d: got pc=%h res=%h want pc=%h res=%h", cyc, wb_pc, wb_result, mq[0].pc, exp_res);
                end
            end

            ra[0] = fwd_raddr1; ra[1] = fwd_raddr2;
            got_fwd[0] = {fwd_hit1, fwd_rdy1, 1'b0}; got_fwd[1] = {fwd_hit2, fwd_rdy2, 1'b0};
            got_fdata[0] = fwd_data1; got_fdata[1] = fwd_data2;
            for (int p = 0; p < 2; p++) begin
                e_hit = 1'b0; e_rdy = 1'b0; e_data = '0;
                foreach (mq[j]) begin
                    if (ra[p] != 5'd0 && mq[j].gr_we && mq[j].dest == ra[p]) begin
                        e_hit  = 1'b1;
                        e_rdy  = !(mq[j].load && mq[j].mem) || mq[j].got;
                        e_data = (mq[j].load && mq[j].mem) ? mq[j].data : mq[j].alu;
                    end
                end
                n_cmp++;
                if (got_fwd[p][2] !== e_hit || (e_hit && (got_fwd[p][1] !== e_rdy ||
                    (e_rdy && got_fdata[p] !== e_data)))) begin
                    n_err++;
                    $display("[TB] FAIL rnd_fwd%0d cyc %0d: got hit=%b rdy=%b %h want %b %b %h", p + 1, cyc,
                             got_fwd[p][2], got_fwd[p][1], got_fdata[p], e_hit, e_rdy, e_data);
                end
            end

            accept = exe_to_mem_valid && exp_allowin;
            if (flush) begin
                discard = discard + waiting + int'(accept && ne.mem && !ne.ex) - int'(data_sram_data_ok);
                mq.delete();
            end else begin
                if (data_sram_data_ok) begin
                    if (discard > 0) discard--;
                    else if (tgt >= 0) begin mq[tgt].got = 1'b1; mq[tgt].data = arrive; end
                end
                if (exp_valid && wb_allowin) void'(mq.pop_front());
                if (accept) begin
                    if (ne.ex) begin ne.mem = 1'b0; ne.load = 1'b0; end
                    mq.push_back(ne);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_bypass();
        test_align();
        test_in_order();
        test_flush_discard();
        test_flush_same_cycle();
        test_forward();
        test_exception();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
